// File: rtl/tt_lfsr_scram.sv
// Serial LFSR engine: parity filter, free-running LFSR, and multiplicative
// (self-synchronising) scrambler/descrambler over a DEPTH-stage shift register.
module tt_lfsr_scram #(
    parameter int unsigned      DEPTH = 13,
    parameter logic [DEPTH-1:0] TAPS  = {DEPTH{1'b1}},
    parameter logic [DEPTH-1:0] SEED  = {{(DEPTH-1){1'b0}}, 1'b1},
    parameter int unsigned      CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             step,
    input  logic             in_bit,
    input  logic             load,
    input  logic [DEPTH-1:0] seed_in,
    output logic             out_valid,
    output logic             out_bit,
    output logic [DEPTH-1:0] state,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             lockup
);

    typedef enum logic [1:0] {
        ModeFilter     = 2'b00,
        ModeLfsr       = 2'b01,
        ModeScramble   = 2'b10,
        ModeDescramble = 2'b11
    } mode_e;

    logic [DEPTH-1:0] r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             r_out;
    logic             r_lock;

    mode_e            w_mode;
    logic             w_fb;
    logic             w_in_xor;
    logic             w_zero;
    logic             w_shift_in;
    logic             w_result;
    logic [DEPTH-1:0] w_next_state;

    // Bit 0 of the register is s[1], the newest stage.
    always_comb begin
        w_mode       = mode_e'(mode);
        w_fb         = ^(r_state & TAPS);
        w_in_xor     = in_bit ^ w_fb;
        w_zero       = (r_state == '0);
        w_shift_in   = in_bit;
        case (w_mode)
            ModeFilter:     w_shift_in = in_bit;
            ModeLfsr:       w_shift_in = w_fb;
            ModeScramble:   w_shift_in = w_in_xor;
            ModeDescramble: w_shift_in = in_bit;
            default:        w_shift_in = in_bit;
        endcase
        w_next_state = {r_state[DEPTH-2:0], w_shift_in};
        w_result     = 1'b0;
        case (w_mode)
            ModeFilter:     w_result = ^(w_next_state & TAPS);
            ModeLfsr:       w_result = w_fb;
            ModeScramble:   w_result = w_in_xor;
            ModeDescramble: w_result = w_in_xor;
            default:        w_result = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_out   <= 1'b0;
            r_lock  <= 1'b0;
        end else if (load) begin
            r_state <= seed_in;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_lock  <= 1'b0;
        end else if (step) begin
            r_valid <= 1'b1;
            r_cnt   <= r_cnt + 1'b1;
            // An all-zero LFSR would never leave zero; reload and flag it.
            if (w_mode == ModeLfsr && w_zero) begin
                r_state <= SEED;
                r_out   <= 1'b0;
                r_lock  <= 1'b1;
            end else begin
                r_state <= w_next_state;
                r_out   <= w_result;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign state     = r_state;
    assign bit_cnt   = r_cnt;
    assign out_valid = r_valid;
    assign out_bit   = r_out;
    assign lockup    = r_lock;

endmodule

// File: tb/tb_tt_lfsr_scram.sv
// Bench for tt_lfsr_scram: directed and random steps checked against a queue-based
// model of the shift register, plus scrambler/descrambler loopback and a 4-stage LFSR.
module tb_tt_lfsr_scram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, DEPTH=13, default taps/seed
    logic        rst_n = 1'b1, step = 1'b0, in_bit = 1'b0, load = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [12:0] seed_in = '0;
    logic        out_valid, out_bit, lockup;
    logic [12:0] state;
    logic [15:0] bit_cnt;

    // Descrambler instance for loopback
    logic        ds_rst = 1'b1, ds_step = 1'b0, ds_in = 1'b0, ds_load = 1'b0;
    logic [1:0]  ds_mode = 2'b11;
    logic [12:0] ds_seed = '0;
    logic        ds_valid, ds_out, ds_lock;
    logic [12:0] ds_state;
    logic [15:0] ds_cnt;

    // 4-stage LFSR instance
    logic        d4_rst = 1'b1, d4_step = 1'b0, d4_in = 1'b0, d4_load = 1'b0;
    logic [1:0]  d4_mode = 2'b01;
    logic [3:0]  d4_seed = '0;
    logic        d4_valid, d4_out, d4_lock;
    logic [3:0]  d4_state;
    logic [15:0] d4_cnt;

    tt_lfsr_scram u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .step(step), .in_bit(in_bit), .load(load),
        .seed_in(seed_in), .out_valid(out_valid), .out_bit(out_bit), .state(state),
        .bit_cnt(bit_cnt), .lockup(lockup)
    );

    tt_lfsr_scram u_desc (
        .clk(clk), .rst_n(ds_rst), .mode(ds_mode), .step(ds_step), .in_bit(ds_in),
        .load(ds_load), .seed_in(ds_seed), .out_valid(ds_valid), .out_bit(ds_out),
        .state(ds_state), .bit_cnt(ds_cnt), .lockup(ds_lock)
    );

    tt_lfsr_scram #(.DEPTH(4), .TAPS(4'b1100), .SEED(4'b0001)) u_d4 (
        .clk(clk), .rst_n(d4_rst), .mode(d4_mode), .step(d4_step), .in_bit(d4_in),
        .load(d4_load), .seed_in(d4_seed), .out_valid(d4_valid), .out_bit(d4_out),
        .state(d4_state), .bit_cnt(d4_cnt), .lockup(d4_lock)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: hist[i-1] is stage s[i], i.e. the i-th most recently shifted bit.
    logic [12:0] taps13 = '1;
    logic [12:0] seed13 = 13'd1;
    bit          hist[$];
    bit          m_valid, m_out, m_lock;
    int unsigned m_cnt;

    function automatic logic [12:0] m_state();
        logic [12:0] v;
        for (int i = 0; i < 13; i++) v[i] = hist[i];
        return v;
    endfunction

    task automatic m_set(input logic [12:0] v);
        hist = {};
        for (int i = 0; i < 13; i++) hist.push_back(v[i]);
    endtask

    task automatic m_reset();
        m_set('0);
        m_valid = 0; m_out = 0; m_lock = 0; m_cnt = 0;
    endtask

    task automatic m_load(input logic [12:0] v);
        m_set(v);
        m_valid = 0; m_lock = 0; m_cnt = 0;
    endtask

    task automatic m_step(input logic [1:0] md, input bit ib);
        bit fb = 0, allz = 1, x, y, par = 0;
        for (int i = 0; i < 13; i++) begin
            fb ^= taps13[i] & hist[i];
            if (hist[i]) allz = 0;
        end
        m_valid = 1;
        m_cnt = (m_cnt + 1) % 65536;
        if (md == 2'b01 && allz) begin
            m_set(seed13);
            m_out = 0;
            m_lock = 1;
            return;
        end
        y = ib ^ fb;
        case (md)
            2'b00:   x = ib;
            2'b01:   x = fb;
            2'b10:   x = y;
            default: x = ib;
        endcase
        hist.push_front(x);
        void'(hist.pop_back());
        for (int i = 0; i < 13; i++) par ^= taps13[i] & hist[i];
        case (md)
            2'b00:   m_out = par;
            2'b01:   m_out = fb;
            default: m_out = y;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic r, input logic ld, input logic [12:0] sd, input logic st,
                       input logic [1:0] md, input logic ib, input string tag);
        rst_n = r; load = ld; seed_in = sd; step = st; mode = md; in_bit = ib;
        tick();
        if (r) m_reset();
        else if (ld) m_load(sd);
        else if (st) m_step(md, ib);
        else m_valid = 0;
        rst_n = 0; load = 0; step = 0;
        chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, "_out"}, 32'(out_bit), 32'(m_out));
        chk({tag, "_state"}, 32'(state), 32'(m_state()));
        chk({tag, "_cnt"}, 32'(bit_cnt), m_cnt);
        chk({tag, "_lock"}, 32'(lockup), 32'(m_lock));
    endtask

    bit          dat[64];
    bit          scr[64];
    logic [12:0] sv;

    initial begin
        m_reset();
        // Reset all instances
        tick();
        ds_rst = 0; d4_rst = 0;
        cyc(1, 0, '0, 0, 2'b00, 0, "reset");
        chk("reset_state0", 32'(state), 0);

        // Parity filter over all taps: a single 1 is seen for exactly 13 steps
        for (int k = 0; k < 14; k++) begin
            cyc(0, 0, '0, 1, 2'b00, k == 0, "filt");
            chk("filt_const", 32'(out_bit), 32'(k < 13));
        end
        chk("filt_cnt14", 32'(bit_cnt), 14);

        // Lockup on an all-zero LFSR step, cleared by load
        cyc(1, 0, '0, 0, 2'b00, 0, "lk_rst");
        cyc(0, 0, '0, 1, 2'b01, 0, "lk_step");
        chk("lk_out0", 32'(out_bit), 0);
        chk("lk_seed", 32'(state), 1);
        chk("lk_flag", 32'(lockup), 1);
        cyc(0, 0, '0, 1, 2'b01, 0, "lk_sticky");
        cyc(0, 1, 13'h0AB, 0, 2'b01, 0, "lk_load");
        chk("lk_clear", 32'(lockup), 0);

        // Load beats a simultaneous step
        cyc(0, 0, '0, 1, 2'b10, 1, "pri_pre");
        cyc(0, 1, 13'h1234, 1, 2'b10, 1, "pri");
        chk("pri_state", 32'(state), 32'h1234);
        chk("pri_cnt", 32'(bit_cnt), 0);
        chk("pri_valid", 32'(out_valid), 0);

        // Random mix of modes, idle cycles, loads (some zero) and rare resets
        for (int k = 0; k < 300; k++) begin
            logic r, ld, st;
            logic [12:0] sd;
            r  = ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 24) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 13'd0 : 13'($urandom_range(0, 8191));
            st = ($urandom_range(0, 3) != 0);
            cyc(r, ld, sd, st, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd");
        end

        // Reset mid-run after scrambling
        cyc(1, 0, '0, 0, 2'b00, 0, "mr_rst0");
        for (int k = 0; k < 7; k++) cyc(0, 0, '0, 1, 2'b10, 1'($urandom_range(0, 1)), "mr_scr");
        cyc(1, 0, '0, 1, 2'b10, 1, "mr_rst");
        chk("mr_state", 32'(state), 0);
        chk("mr_cnt", 32'(bit_cnt), 0);
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_lock", 32'(lockup), 0);
        cyc(0, 0, '0, 1, 2'b10, 1, "mr_first");
        chk("mr_first_state", 32'(state), 1);
        chk("mr_first_out", 32'(out_bit), 1);

        // Loopback: pass 0 same seed, pass 1 different seeds (sync after 13 bits)
        for (int pass = 0; pass < 2; pass++) begin
            sv = 13'($urandom_range(1, 8191));
            for (int i = 0; i < 64; i++) dat[i] = 1'($urandom_range(0, 1));
            seed_in = sv; load = 1;
            ds_seed = (pass == 0) ? sv : ~sv; ds_load = 1;
            tick();
            m_load(sv);
            load = 0; ds_load = 0;
            for (int k = 0; k <= 64; k++) begin
                step = (k < 64); mode = 2'b10; in_bit = (k < 64) ? dat[k] : 1'b0;
                ds_step = (k > 0); ds_mode = 2'b11; ds_in = (k > 0) ? scr[k-1] : 1'b0;
                tick();
                step = 0; ds_step = 0;
                if (k < 64) begin
                    m_step(2'b10, dat[k]);
                    scr[k] = out_bit;
                    chk("lb_scr", 32'(out_bit), 32'(m_out));
                end
                if (k > 0 && (pass == 0 || k - 1 >= 13)) begin
                    chk("lb_desc_valid", 32'(ds_valid), 1);
                    chk("lb_desc", 32'(ds_out), 32'(dat[k-1]));
                end
            end
        end

        // 4-stage maximal LFSR returns to its seed after exactly 15 steps
        d4_load = 1; d4_seed = 4'b0001;
        tick();
        d4_load = 0;
        chk("d4_load_cnt", 32'(d4_cnt), 0);
        for (int n = 1; n <= 15; n++) begin
            d4_step = 1; d4_mode = 2'b01;
            tick();
            d4_step = 0;
            if (n < 15) chk("d4_early", 32'(d4_state == 4'b0001), 0);
            else chk("d4_period", 32'(d4_state), 32'b0001);
        end
        chk("d4_cnt15", 32'(d4_cnt), 15);
        chk("d4_nolock", 32'(d4_lock), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tt_lfsr_scram.md
TT_LFSR_SCRAM -- requirements
Module: tt_lfsr_scram

Interface
REQ-001 Parameter DEPTH, default 13: shift-register length; legal range 2..32.
REQ-002 Parameter TAPS, default all-ones (DEPTH bits): tap mask; bit i-1 selects stage s[i]; SHALL be nonzero.
REQ-003 Parameter SEED, default 1 (DEPTH bits): lockup reload value; SHALL be nonzero.
REQ-004 Parameter CNT_W, default 16: step-counter width.
REQ-005 clk  in  1  sole clock; all state changes on posedge clk.
REQ-006 rst_n  in  1  reset: one clock; reset is synchronous and active-high.
REQ-007 mode  in  2  00 FILTER, 01 LFSR, 10 SCRAMBLE, 11 DESCRAMBLE; sampled only on an accepted step.
REQ-008 step  in  1  advance strobe; one bit processed per cycle where step=1.
REQ-009 in_bit  in  1  serial data; ignored in LFSR mode.
REQ-010 load  in  1  seed-load strobe.
REQ-011 seed_in  in  DEPTH  value written to the register on load.
REQ-012 out_valid  out  1  out_bit holds a fresh result this cycle.
REQ-013 out_bit  out  1  registered result bit.
REQ-014 state  out  DEPTH  register contents; state[i-1] = s[i], s[1] newest.
REQ-015 bit_cnt  out  CNT_W  accepted-step count.
REQ-016 lockup  out  1  sticky all-zero-state-in-LFSR indicator.

Function
REQ-017 fb SHALL be the XOR over i=1..DEPTH of (TAPS[i-1] AND s[i]), computed on the pre-step state.
REQ-018 Accepted step (step=1, load=0): s <= {s[DEPTH-1:1], x}, with x shifted into s[1] and s[DEPTH] discarded.
REQ-019 FILTER: x = in_bit; out_bit <= XOR over TAPS of the post-shift state (parity of the masked new state).
REQ-020 LFSR: x = fb; out_bit <= fb.
REQ-021 SCRAMBLE (multiplicative): y = in_bit XOR fb; x = y; out_bit <= y.
REQ-022 DESCRAMBLE: y = in_bit XOR fb; x = in_bit; out_bit <= y; this mode SHALL self-synchronise after DEPTH steps.
REQ-023 Latency: out_valid=1 and out_bit are valid in the cycle after the accepted step; otherwise out_valid=0 and out_bit holds its last value.
REQ-024 bit_cnt SHALL increment by 1 per accepted step, wrapping from 2^CNT_W-1 to 0.
REQ-025 load=1 has priority over step: s <= seed_in, bit_cnt <= 0, lockup <= 0, out_valid <= 0; a simultaneous step is dropped and not counted.
REQ-026 LFSR step with s==0: s <= SEED, out_bit <= 0, out_valid <= 1, lockup <= 1, bit_cnt increments; no other mode checks for lockup.
REQ-027 A mode change between steps SHALL NOT alter s; the new mode applies from the next accepted step.
REQ-028 lockup SHALL clear only on reset or load.

Reset
REQ-029 While rst_n=1 at posedge clk: s=0, out_valid=0, out_bit=0, bit_cnt=0, lockup=0; reset overrides load and step.
REQ-030 Reset asserted mid-stream SHALL discard all pending state; the first step after release behaves as the first step from all-zero.

Verification
REQ-031 FILTER, DEPTH=13, TAPS all-ones, reset then step with in_bit 1,0,0,... -> out_bit=1 for steps 1..13, 0 from step 14; bit_cnt=14.
REQ-032 LFSR, DEPTH=4, TAPS=4'b1100, load seed_in=4'b0001, 15 steps -> state returns to 4'b0001 exactly at step 15, not earlier; bit_cnt=15.
REQ-033 Loopback: SCRAMBLE instance feeds DESCRAMBLE instance, both DEPTH=13, same seed, 64 random in_bit -> descrambler output equals the input bit-for-bit; with different seeds, it matches from bit 14 onward.
REQ-034 Lockup: reset, LFSR mode, one step -> out_bit=0, state=SEED, lockup=1; a following load clears lockup.
REQ-035 Priority: load=1 and step=1 in the same cycle -> state=seed_in, bit_cnt=0, out_valid=0 next cycle.
REQ-036 Reset mid-run after 7 SCRAMBLE steps -> next cycle state=0, bit_cnt=0, out_valid=0, lockup=0.
